// File: rtl/serial_word_packer_m5_pkg.sv
// serial_word_packer_m5_pkg: shared types and the mod-5 step table for the serial word packer
package serial_word_packer_m5_pkg;
  typedef enum logic {SHIFT, HOLD} state_t;
  typedef enum logic [2:0] {R0, R1, R2, R3, R4} rem_t;
  function automatic rem_t mod5_next(rem_t r, logic b);
    case (r)
      R0: return b ? R1 : R0;
      R1: return b ? R3 : R2;
      R2: return b ? R0 : R4;
      R3: return b ? R2 : R1;
      R4: return b ? R4 : R3;
      default: return R0;
    endcase
  endfunction
endpackage

// File: rtl/serial_word_packer_m5_mod5_rem_fsm.sv
// serial_word_packer_m5_mod5_rem_fsm: running remainder mod 5 of an MSB-first bit stream
module serial_word_packer_m5_mod5_rem_fsm
  import serial_word_packer_m5_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic din,
  output rem_t rem
);
  // clr restarts from R0 on the same bit it accompanies
  always_ff @(posedge clk)
    if (rst) rem <= R0;
    else if (bit_vld) rem <= mod5_next(clr ? R0 : rem, din);
endmodule

// File: rtl/serial_word_packer_m5.sv
// serial_word_packer_m5: MSB-first bit-serial to WIDTH-bit word packer with valid/ready output; MOD5_CHECK_EN adds mult5
module serial_word_packer_m5
  import serial_word_packer_m5_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             sin_sync,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout_word,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             mult5,
  output logic             drop
);
  localparam int CNT_W = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt;
  logic acc, drain, done, load, m5_new, m5_held;
  assign sin_ready = state == SHIFT && !rst;
  assign acc = sin_valid && sin_ready;
  assign drain = dout_valid && dout_ready;
  assign done = acc && !sin_sync && cnt == CNT_W'(WIDTH - 1);
  assign load = done && (!dout_valid || dout_ready);
  assign shreg_nxt = sin_sync ? WIDTH'(sin_bit) : {shreg[WIDTH-2:0], sin_bit};
`ifdef MOD5_CHECK_EN
  rem_t rem;
  serial_word_packer_m5_mod5_rem_fsm u_rem (
    .clk(clk),
    .rst(rst),
    .clr(cnt == '0 || sin_sync),
    .bit_vld(acc),
    .din(sin_bit),
    .rem(rem)
  );
  assign m5_new = mod5_next(rem, sin_bit) == R0;
  assign m5_held = rem == R0;
`else
  assign m5_new = 1'b0;
  assign m5_held = 1'b0;
`endif
  // state register
  always_ff @(posedge clk) state <= rst ? SHIFT : state_nxt;
  // park a completed word in HOLD when the output register cannot take it
  always_comb begin
    state_nxt = state;
    state_nxt = (state == SHIFT) ? ((done && !load) ? HOLD : SHIFT) : (drain ? SHIFT : HOLD);
  end
  // shift register, bit counter and output register
  always_ff @(posedge clk)
    if (rst) begin
      shreg <= '0;
      cnt <= '0;
      dout_word <= '0;
      dout_valid <= 1'b0;
      mult5 <= 1'b0;
      drop <= 1'b0;
    end else begin
      drop <= acc && sin_sync && cnt != '0;
      if (acc) begin
        shreg <= shreg_nxt;
        cnt <= sin_sync ? CNT_W'(1) : done ? '0 : cnt + CNT_W'(1);
      end
      if (load) begin
        dout_word <= shreg_nxt;
        mult5 <= m5_new;
        dout_valid <= 1'b1;
      end else if (state == HOLD && drain) begin
        dout_word <= shreg;
        mult5 <= m5_held;
      end else if (drain) dout_valid <= 1'b0;
    end
endmodule

// File: tb/tb_serial_word_packer_m5.sv
// tb_serial_word_packer_m5: scoreboard bench for serial_word_packer_m5 (mult5 expectations follow MOD5_CHECK_EN)
module tb_serial_word_packer_m5;
  logic clk = 0, rst = 1, sin_valid = 0, sin_bit = 0, sin_sync = 0, dout_ready = 1;
  logic sin_ready, dout_valid, mult5, drop;
  logic [5:0] dout_word;
  typedef struct packed {logic [5:0] w; logic m;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, popped = 0, pushed = 0, drop_cnt = 0, cyc = 0;
  logic prev_stall = 0, prev_m5 = 0, sweep_done = 0;
  logic [5:0] prev_word = 0;

  serial_word_packer_m5 #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit), .sin_sync(sin_sync),
    .sin_ready(sin_ready), .dout_word(dout_word), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .mult5(mult5), .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_m5(input logic m);
`ifdef MOD5_CHECK_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic s);
    int n = 0;
    sin_valid = 1; sin_bit = b; sin_sync = s;
    @(negedge clk);
    while (!sin_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: got sin_ready=0 expected 1 within 200 cycles");
    end
    step();
    sin_valid = 0; sin_sync = 0;
  endtask

  task automatic send_word(input logic [5:0] w, input logic m);
    q.push_back('{w: w, m: exp_m5(m)});
    pushed++;
    for (int i = 5; i >= 0; i--) send(w[i], 1'b0);
  endtask

  // scoreboard monitor, output stability and drop counting
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall && dout_valid) begin
        chk("stable_word", 32'(dout_word), 32'(prev_word));
        chk("stable_mult5", 32'(mult5), 32'(prev_m5));
      end
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h expected none", dout_word);
        end else begin
          e = q.pop_front();
          chk("word", 32'(dout_word), 32'(e.w));
          chk("mult5", 32'(mult5), 32'(e.m));
          popped++;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_word = dout_word;
      prev_m5 = mult5;
    end
    if (drop) drop_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, n;
    @(negedge clk);
    chk("rst_sin_ready", 32'(sin_ready), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_dout_word", 32'(dout_word), 0);
    chk("rst_mult5", 32'(mult5), 0);
    chk("rst_drop", 32'(drop), 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_sin_ready", 32'(sin_ready), 1);
    step();
    // single word 0x0A, valid exactly one cycle
    send_word(6'h0A, 1'b1);
    @(negedge clk);
    chk("t1_valid_rise", 32'(dout_valid), 1);
    @(negedge clk);
    chk("t1_valid_fall", 32'(dout_valid), 0);
    step();
    // back-to-back words, no input bubble
    c0 = cyc;
    send_word(6'h3F, 1'b0);
    send_word(6'h00, 1'b1);
    chk("t2_cycles", 32'(cyc - c0), 12);
    repeat (3) step();
    // backpressure: two words while stalled
    dout_ready = 0;
    send_word(6'h05, 1'b1);
    send_word(6'h07, 1'b0);
    @(negedge clk);
    chk("t3_sin_ready_low", 32'(sin_ready), 0);
    chk("t3_hold_word", 32'(dout_word), 32'h05);
    chk("t3_hold_valid", 32'(dout_valid), 1);
    repeat (3) step();
    dout_ready = 1;
    repeat (3) step();
    chk("t3_sin_ready_back", 32'(sin_ready), 1);
    chk("t3_drained", 32'(dout_valid), 0);
    // resync after a 3-bit partial word
    d0 = drop_cnt;
    q.push_back('{w: 6'h38, m: exp_m5(1'b0)});
    pushed++;
    send(1, 0); send(0, 0); send(1, 0);
    send(1, 1); send(1, 0); send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    repeat (3) step();
    chk("t4_drop_pulses", 32'(drop_cnt - d0), 1);
    // reset mid-word
    send(1, 0); send(1, 0); send(0, 0); send(1, 0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_sin_ready", 32'(sin_ready), 0);
    chk("t5_rst_valid", 32'(dout_valid), 0);
    chk("t5_rst_word", 32'(dout_word), 0);
    chk("t5_rst_mult5", 32'(mult5), 0);
    chk("t5_rst_drop", 32'(drop), 0);
    step();
    rst = 0;
    send_word(6'h14, 1'b1);
    repeat (3) step();
    // sweep all words with random output stalls
    fork
      begin
        for (int i = 0; i < 64; i++) send_word(6'(i), (i % 5) == 0);
        sweep_done = 1;
      end
      begin
        while (!sweep_done) begin
          step();
          dout_ready = $urandom_range(0, 2) != 0;
        end
        dout_ready = 1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    repeat (2) step();
    chk("sb_empty", 32'(q.size()), 0);
    chk("words_out", 32'(popped), 32'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
